// File: rtl/regread_stage.sv
// Register-read stage: write-enable decode for the register bank, operand select with
// same-cycle write-back bypass, and a stall/flush-capable pipeline register toward execute.
module regread_stage #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rf_out [NREGS-1:0],
    output logic [NREGS-1:0]         rf_we,
    output logic [WIDTH-1:0]         rf_wdata,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_idx,
    input  logic [WIDTH-1:0]         wb_data,
    input  logic                     in_valid,
    input  logic [$clog2(NREGS)-1:0] rd_a_idx,
    input  logic [$clog2(NREGS)-1:0] rd_b_idx,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    output logic [$clog2(NREGS)-1:0] op_a_idx,
    output logic [$clog2(NREGS)-1:0] op_b_idx
);

    localparam int IDXW = $clog2(NREGS);
    localparam logic [IDXW-1:0] ZIDX = IDXW'(ZERO_REG);

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             wb_live;
    logic             refresh_a;
    logic             refresh_b;

    // A write-back aimed at the zero register is ignored everywhere.
    assign wb_live = wb_en && (wb_idx != ZIDX);

    always_comb begin
        rf_we = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i != ZERO_REG)
                rf_we[i] = wb_live && (wb_idx == IDXW'(i));
        end
    end

    assign rf_wdata = wb_data;

    // The bank only updates at the next edge, so a matching write-back is forwarded here.
    always_comb begin
        sel_a = rf_out[rd_a_idx];
        if (rd_a_idx == ZIDX)
            sel_a = '0;
        else if (wb_live && (wb_idx == rd_a_idx))
            sel_a = wb_data;
    end

    always_comb begin
        sel_b = rf_out[rd_b_idx];
        if (rd_b_idx == ZIDX)
            sel_b = '0;
        else if (wb_live && (wb_idx == rd_b_idx))
            sel_b = wb_data;
    end

    assign in_ready = !stall;

    // Held operands absorb a write-back to their register so they never go stale during a stall.
    assign refresh_a = wb_live && (wb_idx == op_a_idx);
    assign refresh_b = wb_live && (wb_idx == op_b_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_a_idx  <= '0;
            op_b_idx  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (stall) begin
            if (refresh_a)
                op_a <= wb_data;
            if (refresh_b)
                op_b <= wb_data;
        end else begin
            out_valid <= in_valid;
            op_a      <= sel_a;
            op_b      <= sel_b;
            op_a_idx  <= rd_a_idx;
            op_b_idx  <= rd_b_idx;
        end
    end

endmodule

// File: tb/tb_regread_stage.sv
// Directed bench for regread_stage: reset, reads, bypass, zero register, stall refresh,
// flush priority and reset during stall.
module tb_regread_stage;

    localparam int WIDTH = 64;
    localparam int NREGS = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] rf_out [NREGS-1:0];
    logic [NREGS-1:0] rf_we;
    logic [WIDTH-1:0] rf_wdata;
    logic             wb_en;
    logic [4:0]       wb_idx;
    logic [WIDTH-1:0] wb_data;
    logic             in_valid;
    logic [4:0]       rd_a_idx;
    logic [4:0]       rd_b_idx;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       op_a_idx;
    logic [4:0]       op_b_idx;

    int n_tests = 0;
    int n_fail  = 0;

    regread_stage dut (
        .clk      (clk),
        .reset    (reset),
        .rf_out   (rf_out),
        .rf_we    (rf_we),
        .rf_wdata (rf_wdata),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .in_valid (in_valid),
        .rd_a_idx (rd_a_idx),
        .rd_b_idx (rd_b_idx),
        .in_ready (in_ready),
        .stall    (stall),
        .flush    (flush),
        .out_valid(out_valid),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_a_idx (op_a_idx),
        .op_b_idx (op_b_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) rf_out[i] = '0;
        reset = 1'b1; wb_en = 1'b0; wb_idx = '0; wb_data = '0;
        in_valid = 1'b1; rd_a_idx = 5'd3; rd_b_idx = 5'd7;
        stall = 1'b0; flush = 1'b0;

        // reset held two cycles with in_valid high
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_a_idx", op_a_idx, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_ready", in_ready, 1);

        // basic read
        reset = 1'b0;
        rf_out[3] = 64'h1111; rf_out[7] = 64'h2222;
        tick();
        chk("rd_valid", out_valid, 1);
        chk("rd_op_a", op_a, 64'h1111);
        chk("rd_op_b", op_b, 64'h2222);
        chk("rd_a_idx", op_a_idx, 3);
        chk("rd_b_idx", op_b_idx, 7);

        // bypass on both ports naming the same register
        wb_en = 1'b1; wb_idx = 5'd5; wb_data = 64'hDEAD;
        rd_a_idx = 5'd5; rd_b_idx = 5'd5;
        #1;
        chk("byp_we", rf_we, 32'h0000_0020);
        chk("byp_wdata", rf_wdata, 64'hDEAD);
        tick();
        chk("byp_op_a", op_a, 64'hDEAD);
        chk("byp_op_b", op_b, 64'hDEAD);

        // write enable for index 0
        wb_idx = 5'd0; wb_data = 64'h77;
        #1;
        chk("we_idx0", rf_we, 32'h0000_0001);

        // zero register: no enable, no bypass, bank content ignored
        rf_out[31] = 64'h5555;
        wb_idx = 5'd31; wb_data = 64'hFFFF;
        rd_a_idx = 5'd31; rd_b_idx = 5'd31;
        #1;
        chk("zr_we", rf_we, 0);
        tick();
        chk("zr_valid", out_valid, 1);
        chk("zr_op_a", op_a, 0);
        chk("zr_op_b", op_b, 0);

        // in_valid low loads a bubble
        wb_en = 1'b0; in_valid = 1'b0;
        tick();
        chk("bubble_valid", out_valid, 0);

        // load A=r2, B=r7, then stall three cycles with write-backs landing
        in_valid = 1'b1;
        rf_out[2] = 64'hA; rd_a_idx = 5'd2; rd_b_idx = 5'd7;
        tick();
        chk("st_load_a", op_a, 64'hA);
        stall = 1'b1;
        rf_out[4] = 64'h4444; rd_a_idx = 5'd4; rd_b_idx = 5'd3;
        #1;
        chk("st_ready1", in_ready, 0);
        tick();
        chk("st1_op_a", op_a, 64'hA);
        chk("st1_valid", out_valid, 1);
        wb_en = 1'b1; wb_idx = 5'd2; wb_data = 64'hB;
        #1;
        chk("st_ready2", in_ready, 0);
        tick();
        chk("st2_op_a", op_a, 64'hB);
        chk("st2_op_b", op_b, 64'h2222);
        chk("st2_a_idx", op_a_idx, 2);
        chk("st2_b_idx", op_b_idx, 7);
        chk("st2_valid", out_valid, 1);
        wb_idx = 5'd7; wb_data = 64'hC;
        #1;
        chk("st_ready3", in_ready, 0);
        tick();
        chk("st3_op_a", op_a, 64'hB);
        chk("st3_op_b", op_b, 64'hC);
        wb_en = 1'b0; stall = 1'b0;
        #1;
        chk("st_ready_rel", in_ready, 1);
        tick();
        chk("st_new_a", op_a, 64'h4444);
        chk("st_new_b", op_b, 64'h1111);
        chk("st_new_a_idx", op_a_idx, 4);
        chk("st_new_b_idx", op_b_idx, 3);

        // flush beats stall
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("fl_stall_valid", out_valid, 0);
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("fl_reload_valid", out_valid, 1);
        // flush alone with in_valid high
        flush = 1'b1;
        #1;
        chk("fl_ready", in_ready, 1);
        tick();
        chk("fl_valid", out_valid, 0);
        flush = 1'b0;
        tick();
        chk("fl_reload2", out_valid, 1);

        // reset while stalled clears the register
        stall = 1'b1; reset = 1'b1;
        tick();
        chk("rst_st_valid", out_valid, 0);
        chk("rst_st_op_a", op_a, 0);
        chk("rst_st_b_idx", op_b_idx, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
